// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the I/D cache memory arbiter: FSM state encoding,
// owner identifiers and the default geometry used by the cache controllers.
package cache_mem_arbiter_pkg;

    // Default widths and burst/fairness limits, shared with the cache controllers
    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 16;
    localparam int BURST_LEN_DEF  = 4;   // one line = one word per bank, four banks
    localparam int MAX_STREAK_DEF = 4;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // nobody owns memory, arbitration happens here
        ST_ISSUE = 2'd1,   // strobe driven, waiting for memory to accept
        ST_WAIT  = 2'd2,   // accepted, waiting for mem_done
        ST_HOLD  = 2'd3    // owner keeps memory between locked accesses
    } arb_state_t;

    // Owner identifiers; also used as the index of the per-port output vectors
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Width of a counter that must hold values 0..max_val inclusive
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_streak_pick.sv
// Winner select for the I/D arbiter. D has fixed priority, but after
// MAX_STREAK consecutive D grants made while I was waiting, I is forced.
module arb_streak_pick
    import cache_mem_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    input  logic in_idle,    // arbiter is in IDLE: a grant is made this cycle if any req
    output logic pick_d,     // 1 = D wins, 0 = I wins (meaningful when any_req)
    output logic any_req
);

    localparam int SW = cnt_width(MAX_STREAK);

    logic [SW-1:0] streak_reg;
    logic          at_max;

    assign at_max  = (streak_reg == SW'(MAX_STREAK));
    assign any_req = i_req || d_req;
    // D wins whenever it asks, except when I has been passed over MAX_STREAK times
    assign pick_d  = d_req && !(i_req && at_max);

    // Count D grants that were made over a waiting I; any I grant or an idle
    // cycle without i_req restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_reg <= '0;
        end else if (in_idle) begin
            if (!i_req) begin
                streak_reg <= '0;
            end else if (!pick_d) begin
                streak_reg <= '0;
            end else if (!at_max) begin
                streak_reg <= streak_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing the banked main memory between the I-cache (port I) and the
// D-cache (port D). One access outstanding at a time; D has priority with a
// starvation guard for I; a lock lets the owner chain up to BURST_LEN accesses.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-cache side
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_lock,
    output logic              i_gnt,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    // D-cache side
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    // Main memory side
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BW = cnt_width(BURST_LEN);

    // Registered state
    arb_state_t        state_reg;
    logic              owner_reg;
    logic              wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [BW-1:0]     burst_cnt_reg;

    // Arbitration and request selection
    logic              pick_d;
    logic              any_req;
    logic              take_d;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              owner_req;
    logic              owner_lock;

    // Completion handling
    logic              issuing;
    logic              access_done;
    logic              chain;

    // Per-port outputs, indexed by OWNER_I / OWNER_D
    logic [1:0]        port_gnt;
    logic [1:0]        port_done;
    logic [DATA_W-1:0] port_rdata [2];

    arb_streak_pick #(
        .MAX_STREAK (MAX_STREAK)
    ) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .d_req   (d_req),
        .in_idle (state_reg == ST_IDLE),
        .pick_d  (pick_d),
        .any_req (any_req)
    );

    // Pick the side whose request fields get latched: the arbitration winner in
    // IDLE, otherwise the current owner (used for HOLD -> ISSUE re-latching).
    always_comb begin
        take_d     = (state_reg == ST_IDLE) ? pick_d : (owner_reg == OWNER_D);
        sel_wr     = take_d ? d_wr    : i_wr;
        sel_addr   = take_d ? d_addr  : i_addr;
        sel_wdata  = take_d ? d_wdata : i_wdata;
        owner_req  = (owner_reg == OWNER_D) ? d_req  : i_req;
        owner_lock = (owner_reg == OWNER_D) ? d_lock : i_lock;
    end

    assign issuing     = (state_reg == ST_ISSUE);
    // A done in the accepting ISSUE cycle covers zero-latency memory
    assign access_done = (issuing && !mem_stall && mem_done) ||
                         ((state_reg == ST_WAIT) && mem_done);
    // Stay with the owner only while it asks for it and the burst has room left
    assign chain       = owner_lock && ((int'(burst_cnt_reg) + 1) < BURST_LEN);

    // Main arbiter FSM with request latch and burst counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWNER_D;
            wr_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            burst_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_reg <= pick_d ? OWNER_D : OWNER_I;
                        wr_reg    <= sel_wr;
                        addr_reg  <= sel_addr;
                        wdata_reg <= sel_wdata;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (access_done) begin
                        if (chain) begin
                            burst_cnt_reg <= burst_cnt_reg + 1'b1;
                            state_reg     <= ST_HOLD;
                        end else begin
                            burst_cnt_reg <= '0;
                            state_reg     <= ST_IDLE;
                        end
                    end else if (issuing && !mem_stall) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (owner_req) begin
                        wr_reg    <= sel_wr;
                        addr_reg  <= sel_addr;
                        wdata_reg <= sel_wdata;
                        state_reg <= ST_ISSUE;
                    end else if (!owner_lock) begin
                        burst_cnt_reg <= '0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory strobes and address/data only while issuing; zero otherwise
    assign mem_rd    = issuing && !wr_reg;
    assign mem_wr    = issuing && wr_reg;
    assign mem_addr  = issuing ? addr_reg : '0;
    assign mem_wdata = (issuing && wr_reg) ? wdata_reg : '0;

    // Per-port grant/done/rdata: only the owner sees done and read data
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign port_gnt[gi]   = (state_reg != ST_IDLE) && (owner_reg == 1'(gi));
            assign port_done[gi]  = access_done && (owner_reg == 1'(gi));
            assign port_rdata[gi] = port_done[gi] ? mem_rdata : '0;
        end
    endgenerate

    assign i_gnt   = port_gnt[OWNER_I];
    assign i_done  = port_done[OWNER_I];
    assign i_rdata = port_rdata[OWNER_I];
    assign d_gnt   = port_gnt[OWNER_D];
    assign d_done  = port_done[OWNER_D];
    assign d_rdata = port_rdata[OWNER_D];

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: behavioural memory with configurable
// latency/stall, request queues per port, and a completion scoreboard.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct packed {
        logic          wr;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic          port;   // 1 = D, 0 = I
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;   // read data or written data
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0, i_wr = 1'b0, i_lock = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_wdata = '0;
    logic          d_req = 1'b0, d_wr = 1'b0, d_lock = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          i_gnt, i_done, d_gnt, d_done;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_stall = 1'b0;
    logic          mem_done = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    req_t iq[$];
    req_t dq[$];
    exp_t sb[$];

    // Memory model controls (written only by the stimulus block)
    int mem_lat   = 1;
    int stall_req = 0;

    // Memory model state
    int            mm_cnt = 0;
    int            mm_stalls = 0;
    logic          mm_busy = 1'b0;
    logic          acc_wr = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_wdata = '0;
    logic [DW-1:0] acc_rdata = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cache_mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .BURST_LEN  (4),
        .MAX_STREAK (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_wr      (i_wr),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_lock    (i_lock),
        .i_gnt     (i_gnt),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_lock    (d_lock),
        .d_gnt     (d_gnt),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_stall (mem_stall),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic req_t mk_req(input logic wr, input logic lock,
                                    input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_t r;
        r.wr = wr; r.lock = lock; r.addr = a; r.wdata = wd;
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic port, input logic wr,
                                    input logic [AW-1:0] a, input logic [DW-1:0] wd);
        exp_t e;
        e.port = port; e.wr = wr; e.addr = a;
        e.data = wr ? wd : rd_model(a);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural memory: stalls stall_req times, then completes mem_lat cycles
    // after acceptance (0 = same cycle). Updates happen on the falling edge.
    always @(negedge clk) begin
        mem_done  <= 1'b0;
        mem_stall <= 1'b0;
        mem_rdata <= '0;
        if (!rst_n) begin
            mm_busy   <= 1'b0;
            mm_cnt    <= 0;
            mm_stalls <= 0;
        end else if (mm_busy) begin
            if (mm_cnt <= 1) begin
                mm_busy   <= 1'b0;
                mem_done  <= 1'b1;
                mem_rdata <= acc_rdata;
            end
            mm_cnt <= mm_cnt - 1;
        end else if (mem_rd || mem_wr) begin
            if (mm_stalls < stall_req) begin
                mem_stall <= 1'b1;
                mm_stalls <= mm_stalls + 1;
            end else begin
                mm_stalls <= 0;
                acc_wr    <= mem_wr;
                acc_addr  <= mem_addr;
                acc_wdata <= mem_wdata;
                acc_rdata <= mem_wr ? '0 : rd_model(mem_addr);
                if (mem_lat == 0) begin
                    mem_done  <= 1'b1;
                    mem_rdata <= mem_wr ? '0 : rd_model(mem_addr);
                end else begin
                    mm_busy <= 1'b1;
                    mm_cnt  <= mem_lat;
                end
            end
        end
    end

    // Scoreboard: every done pops the next expected transaction
    always @(negedge clk) begin
        exp_t e;
        exp_t o;
        #1;
        if (i_done || d_done) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", {62'd0, i_done, d_done}, 64'd0);
            end else begin
                e = sb.pop_front();
                o.port = d_done;
                o.wr   = acc_wr;
                o.addr = acc_addr;
                o.data = acc_wr ? acc_wdata : (d_done ? d_rdata : i_rdata);
                $display("txn cyc=%0d port=%s wr=%0d addr=%h data=%h", cyc,
                         d_done ? "D" : "I", o.wr, o.addr, o.data);
                chk("sb_txn", 64'(o), 64'(e));
                chk("other_rdata_zero", 64'(d_done ? i_rdata : d_rdata), 64'd0);
            end
        end
    end

    task automatic present();
        if (iq.size() > 0) begin
            i_req = 1'b1; i_wr = iq[0].wr; i_lock = iq[0].lock;
            i_addr = iq[0].addr; i_wdata = iq[0].wdata;
        end else begin
            i_req = 1'b0; i_lock = 1'b0;
        end
        if (dq.size() > 0) begin
            d_req = 1'b1; d_wr = dq[0].wr; d_lock = dq[0].lock;
            d_addr = dq[0].addr; d_wdata = dq[0].wdata;
        end else begin
            d_req = 1'b0; d_lock = 1'b0;
        end
    endtask

    // One clock: sample after the falling edge, retire finished requests, drive next
    task automatic step();
        @(negedge clk);
        #1;
        if (i_done && iq.size() > 0) iq.delete(0);
        if (d_done && dq.size() > 0) dq.delete(0);
        present();
    endtask

    task automatic drain(input string tag, input int budget);
        int   n;
        logic drained;
        n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || sb.size() > 0) && n < budget) begin
            step();
            n++;
        end
        drained = (iq.size() == 0 && dq.size() == 0 && sb.size() == 0);
        chk({tag, "_drained"}, 64'(drained), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   dcount;
        logic seen_i;
        logic drained;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_ctl", 64'({i_gnt, i_done, d_gnt, d_done, mem_rd, mem_wr}), 64'd0);
        chk("rst_data", 64'({i_rdata, d_rdata, mem_addr, mem_wdata}), 64'd0);
        chk("rst_state", 64'(dut.state_reg), 64'(ST_IDLE));
        chk("rst_streak", 64'(dut.u_pick.streak_reg), 64'd0);
        rst_n = 1'b1;
        step();

        // ---------------- 1: simultaneous I and D, 3-cycle memory ----------------
        mem_lat = 2;
        iq.push_back(mk_req(1'b0, 1'b0, 16'h1000, 16'h0000));
        dq.push_back(mk_req(1'b0, 1'b0, 16'h0040, 16'h0000));
        sb.push_back(mk_exp(1'b1, 1'b0, 16'h0040, 16'h0000));
        sb.push_back(mk_exp(1'b0, 1'b0, 16'h1000, 16'h0000));
        present();
        step();   // cycle 1: D issue
        chk("t1_c1_strobe", 64'({mem_rd, mem_wr, d_gnt, i_gnt}), 64'b1010);
        chk("t1_c1_addr", 64'(mem_addr), 64'h0040);
        step();   // cycle 2: wait
        chk("t1_c2_wait", 64'({mem_rd, d_gnt, d_done}), 64'b010);
        step();   // cycle 3: d_done
        chk("t1_c3_done", 64'({d_done, i_done}), 64'b10);
        step();   // cycle 4: idle, I wins arbitration
        chk("t1_c4_idle", 64'({mem_rd, d_gnt, i_gnt}), 64'b000);
        step();   // cycle 5: I issue
        chk("t1_c5_istrobe", 64'({mem_rd, i_gnt, d_gnt}), 64'b110);
        chk("t1_c5_addr", 64'(mem_addr), 64'h1000);
        drain("t1", 40);

        // ---------------- 2: starvation guard ----------------
        mem_lat = 1;
        iq.push_back(mk_req(1'b0, 1'b0, 16'h2000, 16'h0000));
        iq.push_back(mk_req(1'b0, 1'b0, 16'h2002, 16'h0000));
        for (int k = 0; k < 6; k++)
            dq.push_back(mk_req(1'b0, 1'b0, 16'(16'h0100 + 2 * k), 16'h0000));
        for (int k = 0; k < 4; k++)
            sb.push_back(mk_exp(1'b1, 1'b0, 16'(16'h0100 + 2 * k), 16'h0000));
        sb.push_back(mk_exp(1'b0, 1'b0, 16'h2000, 16'h0000));
        sb.push_back(mk_exp(1'b1, 1'b0, 16'h0108, 16'h0000));
        sb.push_back(mk_exp(1'b1, 1'b0, 16'h010A, 16'h0000));
        sb.push_back(mk_exp(1'b0, 1'b0, 16'h2002, 16'h0000));
        present();
        seen_i = 1'b0;
        n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || sb.size() > 0) && n < 200) begin
            step();
            n++;
            if (i_gnt && !seen_i) begin
                seen_i = 1'b1;
                chk("t2_streak_after_igrant", 64'(dut.u_pick.streak_reg), 64'd0);
                chk("t2_igrant_after_4d", 64'(dq.size()), 64'd2);
            end
        end
        drained = (iq.size() == 0 && dq.size() == 0 && sb.size() == 0);
        chk("t2_drained", 64'(drained), 64'd1);

        // ---------------- 3: locked D write-back burst ----------------
        iq.push_back(mk_req(1'b0, 1'b0, 16'h3000, 16'h0000));
        for (int k = 0; k < 5; k++) begin
            dq.push_back(mk_req(1'b1, 1'b1, 16'(16'h0200 + 2 * k), 16'(16'hD000 + k)));
            sb.push_back(mk_exp(1'b1, 1'b1, 16'(16'h0200 + 2 * k), 16'(16'hD000 + k)));
        end
        sb.push_back(mk_exp(1'b0, 1'b0, 16'h3000, 16'h0000));
        present();
        dcount = 0;
        n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || sb.size() > 0) && n < 200) begin
            step();
            n++;
            if (dcount < 4)
                chk("t3_burst_owner", 64'({d_gnt, i_gnt}), 64'b10);
            if (d_done) dcount++;
        end
        drained = (iq.size() == 0 && dq.size() == 0 && sb.size() == 0);
        chk("t3_drained", 64'(drained), 64'd1);

        // ---------------- 4: stall with changing write data ----------------
        stall_req = 5;
        dq.push_back(mk_req(1'b1, 1'b0, 16'h0300, 16'hBEEF));
        sb.push_back(mk_exp(1'b1, 1'b1, 16'h0300, 16'hBEEF));
        present();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_stall_strobe", 64'({mem_wr, mem_rd, mem_stall}), 64'b101);
            chk("t4_stall_addr", 64'(mem_addr), 64'h0300);
            chk("t4_stall_wdata", 64'(mem_wdata), 64'hBEEF);
            if (k == 1) begin
                dq[0].wdata = 16'h1234;
                present();
            end
        end
        step();   // accepted with no extra bubble
        chk("t4_accept", 64'({mem_wr, mem_stall}), 64'b10);
        drain("t4", 20);
        stall_req = 0;

        // ---------------- 5: zero-latency memory ----------------
        mem_lat = 0;
        dq.push_back(mk_req(1'b0, 1'b0, 16'hFFFF, 16'h0000));
        sb.push_back(mk_exp(1'b1, 1'b0, 16'hFFFF, 16'h0000));
        present();
        step();
        chk("t5_same_cycle", 64'({mem_rd, d_done, i_done}), 64'b110);
        chk("t5_rdata", 64'(d_rdata), 64'hA5A5);
        chk("t5_i_rdata", 64'(i_rdata), 64'd0);
        step();
        chk("t5_back_idle", 64'({mem_rd, d_gnt, i_gnt}), 64'b000);
        drain("t5", 10);

        // ---------------- 6: reset during WAIT ----------------
        mem_lat = 5;
        dq.push_back(mk_req(1'b0, 1'b0, 16'h0500, 16'h0000));
        present();
        step();   // issue, accepted
        chk("t6_issue", 64'({mem_rd, d_gnt}), 64'b11);
        step();   // wait
        chk("t6_wait", 64'({mem_rd, d_gnt}), 64'b01);
        rst_n = 1'b0;
        dq.delete();
        present();
        #1;
        chk("t6_rst_ctl", 64'({i_gnt, i_done, d_gnt, d_done, mem_rd, mem_wr}), 64'd0);
        chk("t6_rst_data", 64'({i_rdata, d_rdata, mem_addr, mem_wdata}), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_no_done", 64'({d_done, i_done}), 64'd0);
        end
        rst_n = 1'b1;
        mem_lat = 1;
        step();
        iq.push_back(mk_req(1'b0, 1'b0, 16'h0600, 16'h0000));
        sb.push_back(mk_exp(1'b0, 1'b0, 16'h0600, 16'h0000));
        present();
        step();
        chk("t6_after_rst_grant", 64'({mem_rd, i_gnt, d_gnt}), 64'b110);
        chk("t6_after_rst_addr", 64'(mem_addr), 64'h0600);
        drain("t6", 20);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
